// File: rtl/compressor_24_2_acc_ctrl.sv
// Carry-save resolve and accumulate controller behind the 24:2 compressor tree.
// Accepts a programmed number of (sum, carry) beats and returns one signed dot-product result.
module compressor_24_2_acc_ctrl #(
  parameter int IN_SIZE  = 20,
  parameter int ACC_SIZE = 32,
  parameter int LEN_SIZE = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [LEN_SIZE-1:0]        cfg_len_i,
  output logic                       busy_o,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [IN_SIZE-1:0]         in_i [0:1],
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic signed [ACC_SIZE-1:0] out_o,
  output logic                       overflow_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Carry-out is dropped: the tree guarantees the true sum fits in IN_SIZE bits.
  function automatic logic [IN_SIZE-1:0] cs_resolve(input logic [IN_SIZE-1:0] s,
                                                    input logic [IN_SIZE-1:0] c);
    return s + c;
  endfunction

  function automatic logic signed [ACC_SIZE-1:0] sext(input logic signed [IN_SIZE-1:0] p);
    return ACC_SIZE'(p);
  endfunction

  function automatic logic add_ovf(input logic signed [ACC_SIZE-1:0] a,
                                   input logic signed [ACC_SIZE-1:0] b,
                                   input logic signed [ACC_SIZE-1:0] s);
    return (a[ACC_SIZE-1] == b[ACC_SIZE-1]) && (s[ACC_SIZE-1] != a[ACC_SIZE-1]);
  endfunction

  logic [1:0]                 state_q;
  logic [1:0]                 state_d;
  logic [LEN_SIZE-1:0]        len_q;
  logic [LEN_SIZE-1:0]        cnt_q;
  logic                       accept;
  logic                       last_beat;
  logic                       start_go;

  logic signed [IN_SIZE-1:0]  sum_p1;
  logic                       vld_p1;
  logic signed [ACC_SIZE-1:0] addend_p2;
  logic signed [ACC_SIZE-1:0] next_p2;
  logic signed [ACC_SIZE-1:0] acc_p2;
  logic                       ovf_p2;

  assign in_ready_o  = (state_q == RUN);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_o       = acc_p2;
  assign overflow_o  = ovf_p2;

  assign accept    = in_valid_i & in_ready_o;
  assign last_beat = accept && ((cnt_q + LEN_SIZE'(1)) == len_q);
  assign start_go  = (state_q == IDLE) && start_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (cfg_len_i != '0) ? RUN : DONE;
      RUN:     if (last_beat) state_d = DRAIN;
      DRAIN:   if (!vld_p1) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: resolve the carry-save pair at the acceptance edge
  always_ff @(posedge clk_i) begin
    if (accept) sum_p1 <= cs_resolve(in_i[0], in_i[1]);
  end

  // Stage 2: sign-extend and accumulate with wrap and sticky overflow
  assign addend_p2 = sext(sum_p1);
  assign next_p2   = acc_p2 + addend_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
      ovf_p2  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= accept;
      if (start_go) begin
        len_q  <= cfg_len_i;
        cnt_q  <= '0;
        acc_p2 <= '0;
        ovf_p2 <= 1'b0;
      end else begin
        if (accept) cnt_q <= cnt_q + LEN_SIZE'(1);
        if (vld_p1) begin
          acc_p2 <= next_p2;
          if (add_ovf(acc_p2, addend_p2, next_p2)) ovf_p2 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_compressor_24_2_acc_ctrl.sv
// Self-checking bench: 32-bit and 21-bit accumulator instances driven in lockstep,
// checked against hand-computed vectors and an integer reference model.
module tb_compressor_24_2_acc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic [19:0] in_i [0:1];
  logic        out_ready;

  logic        busy32, rdy32, ovld32, ovf32;
  logic [31:0] out32;
  logic        busy21, rdy21, ovld21, ovf21;
  logic [20:0] out21;

  int n_chk  = 0;
  int n_fail = 0;

  logic [19:0] cur_a [0:15];
  logic [19:0] cur_b [0:15];

  typedef struct {
    int              len;
    int              gmode;
    int              hold;
    logic [3:0][19:0] a;
    logic [3:0][19:0] b;
    longint          e32;
    bit              o32;
    longint          e21;
    bit              o21;
  } vec_t;

  vec_t tbl [0:7];

  always #5 clk = ~clk;

  compressor_24_2_acc_ctrl #(.IN_SIZE(20), .ACC_SIZE(32), .LEN_SIZE(8)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_len_i(cfg_len), .busy_o(busy32),
    .in_valid_i(in_valid), .in_ready_o(rdy32), .in_i(in_i), .out_valid_o(ovld32),
    .out_ready_i(out_ready), .out_o(out32), .overflow_o(ovf32));

  compressor_24_2_acc_ctrl #(.IN_SIZE(20), .ACC_SIZE(21), .LEN_SIZE(8)) dut21 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_len_i(cfg_len), .busy_o(busy21),
    .in_valid_i(in_valid), .in_ready_o(rdy21), .in_i(in_i), .out_valid_o(ovld21),
    .out_ready_i(out_ready), .out_o(out21), .overflow_o(ovf21));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Exact integer arithmetic: interpret each resolved beat as a signed 20-bit value,
  // add it, and fold back into the w-bit two's-complement range when it leaves it.
  function automatic void model(input int len, input int w, output longint res, output bit ovf);
    longint m, lo, hi, acc, p, v, s;
    m = longint'(1) <<< w;
    lo = -(m / 2);
    hi = m / 2 - 1;
    acc = 0;
    ovf = 0;
    for (int i = 0; i < len; i++) begin
      p = (longint'(cur_a[i]) + longint'(cur_b[i])) % (longint'(1) <<< 20);
      v = (p >= (longint'(1) <<< 19)) ? p - (longint'(1) <<< 20) : p;
      s = acc + v;
      if (s > hi || s < lo) begin
        ovf = 1;
        s = (s > hi) ? s - m : s + m;
      end
      acc = s;
    end
    res = (acc < 0) ? acc + m : acc;
  endfunction

  function automatic vec_t mk(input int len, input int g, input int h,
                              input logic [19:0] a0, input logic [19:0] b0,
                              input logic [19:0] a1, input logic [19:0] b1,
                              input logic [19:0] a2, input logic [19:0] b2,
                              input logic [19:0] a3, input logic [19:0] b3,
                              input longint e32, input bit o32,
                              input longint e21, input bit o21);
    vec_t t;
    t.len = len; t.gmode = g; t.hold = h;
    t.a[0] = a0; t.a[1] = a1; t.a[2] = a2; t.a[3] = a3;
    t.b[0] = b0; t.b[1] = b1; t.b[2] = b2; t.b[3] = b3;
    t.e32 = e32; t.o32 = o32; t.e21 = e21; t.o21 = o21;
    return t;
  endfunction

  // Called at a falling edge with both instances idle; returns at a falling edge, idle.
  task automatic run_case(input int len, input int gmode, input int hold,
                          input longint e32, input bit o32, input longint e21, input bit o21);
    int k;
    int cyc;
    int lat;
    bit v;
    start = 1'b1; cfg_len = len[7:0]; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; cfg_len = 8'($urandom);
    chk("busy_after_start", busy32, 1);
    if (len == 0) begin
      chk("ready_len0", rdy32, 0);
      chk("valid_len0", ovld32, 1);
    end else begin
      k = 0; cyc = 0;
      while (k < len && cyc < 400) begin
        v = (gmode == 0) ? 1'b1 : (gmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
        in_valid = v; in_i[0] = cur_a[k]; in_i[1] = cur_b[k];
        chk("ready_run", rdy32, 1);
        if (v && rdy32) k++;
        @(negedge clk);
        cyc++;
      end
      chk("beats_accepted", k, len);
      in_valid = 1'b1; in_i[0] = 20'h12345; in_i[1] = 20'h54321;
      chk("ready_drain", rdy32, 0);
      chk("busy_drain", busy32, 1);
      lat = 1;
      while (!ovld32 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk("latency", lat, 3);
    end
    in_valid = 1'b0;
    chk("out32", out32, e32);
    chk("ovf32", ovf32, longint'(o32));
    chk("out21", out21, e21);
    chk("ovf21", ovf21, longint'(o21));
    chk("valid21", ovld21, 1);
    chk("ready_done", rdy32, 0);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0; start = (i % 2 == 0); cfg_len = 8'd3;
      @(negedge clk);
      chk("hold_valid", ovld32, 1);
      chk("hold_out32", out32, e32);
      chk("hold_out21", out21, e21);
      chk("hold_busy", busy32, 1);
    end
    start = 1'b1; out_ready = 1'b1; cfg_len = 8'd2;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    chk("busy_after_hs", busy32, 0);
    chk("valid_after_hs", ovld32, 0);
    chk("idle_hold_out", out32, e32);
    @(negedge clk);
    chk("start_in_hs_ignored", busy32, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint r32, r21;
    bit     v32, v21;
    int     len;

    rst = 1'b1; start = 1'b0; cfg_len = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
    in_i[0] = 20'd0; in_i[1] = 20'd0;

    tbl[0] = mk(3, 0, 1, 20'd100, 20'd23, 20'hFFFFF, 20'd1, 20'd7, 20'd0, 20'd0, 20'd0,
                130, 0, 130, 0);
    tbl[1] = mk(1, 0, 1, 20'hFFFFE, 20'd5, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0);
    tbl[2] = mk(1, 0, 1, 20'h80000, 20'd0, 0, 0, 0, 0, 0, 0, 'hFFF80000, 0, 'h180000, 0);
    tbl[3] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(4, 1, 5, 20'd1, 20'd1, 20'd1, 20'd1, 20'd1, 20'd1, 20'd1, 20'd1, 8, 0, 8, 0);
    tbl[5] = mk(3, 0, 1, 20'h7FFFF, 0, 20'h7FFFF, 0, 20'h7FFFF, 0, 0, 0,
                'h17FFFD, 0, 'h17FFFD, 1);
    tbl[6] = mk(1, 0, 1, 20'd2, 20'd3, 0, 0, 0, 0, 0, 0, 5, 0, 5, 0);
    tbl[7] = mk(3, 2, 2, 20'h80000, 0, 20'h80000, 0, 20'h80000, 0, 0, 0,
                'hFFE80000, 0, 'h080000, 1);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy32, 0);
    chk("rst_ready", rdy32, 0);
    chk("rst_valid", ovld32, 0);
    chk("rst_out32", out32, 0);
    chk("rst_ovf32", ovf32, 0);
    chk("rst_out21", out21, 0);
    chk("rst_busy21", busy21, 0);
    rst = 1'b0;

    // beats offered in IDLE must be ignored
    in_valid = 1'b1; in_i[0] = 20'd77; in_i[1] = 20'd1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready", rdy32, 0);
      chk("idle_busy", busy32, 0);
    end
    in_valid = 1'b0;

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4; i++) begin
        cur_a[i] = tbl[t].a[i];
        cur_b[i] = tbl[t].b[i];
      end
      run_case(tbl[t].len, tbl[t].gmode, tbl[t].hold,
               tbl[t].e32, tbl[t].o32, tbl[t].e21, tbl[t].o21);
    end

    // reset in the middle of a run
    start = 1'b1; cfg_len = 8'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_i[0] = 20'd9; in_i[1] = 20'd9;
    repeat (2) @(negedge clk);
    chk("midrun_acc", out32, 18);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_busy", busy32, 0);
    chk("midrst_ready", rdy32, 0);
    chk("midrst_valid", ovld32, 0);
    chk("midrst_out32", out32, 0);
    chk("midrst_out21", out21, 0);
    cur_a[0] = 20'd4; cur_b[0] = 20'd4;
    run_case(1, 0, 1, 8, 0, 8, 0);

    for (int n = 0; n < 24; n++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0: cur_a[i] = 20'h7FFFF;
          1: cur_a[i] = 20'h80000;
          2: cur_a[i] = 20'($urandom_range(0, 255));
          default: cur_a[i] = 20'($urandom);
        endcase
        cur_b[i] = ($urandom_range(0, 2) == 0) ? 20'd0 : 20'($urandom);
      end
      model(len, 32, r32, v32);
      model(len, 21, r21, v21);
      run_case(len, $urandom_range(0, 2), $urandom_range(0, 3), r32, v32, r21, v21);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
